// File: rtl/alu_nb_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops and a WIDTH-cycle shift-add multiply.
// Handshake: an op is accepted on a rising edge with start=1 and busy=0; done pulses for one cycle when its result lands.
module alu_nb_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_flag,
    output logic             overflow,
    output logic             state_dbg
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic                 accept;
    logic                 mul_last;

    assign accept   = start && (state == IDLE);
    assign mul_last = (state == MUL_RUN) && (cnt == LAST);
    assign mul_step = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (select)
            OP_ADD: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << b[SW-1:0];
            OP_SRL:  alu_res = a >> b[SW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && select == OP_MUL) state_next = MUL_RUN;
            MUL_RUN: if (mul_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == MUL_RUN);
        state_dbg = (state == MUL_RUN);
    end

    // Multiply consumes one multiplier bit per cycle; the last step writes the result directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero_flag <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (select == OP_MUL) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    cnt    <= '0;
                end else begin
                    result    <= alu_res;
                    carry_out <= alu_c;
                    overflow  <= alu_v;
                    zero_flag <= (alu_res == '0);
                    done      <= 1'b1;
                end
            end else if (state == MUL_RUN) begin
                acc    <= mul_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (mul_last) begin
                    result    <= mul_step[WIDTH-1:0];
                    carry_out <= |mul_step[2*WIDTH-1:WIDTH];
                    overflow  <= 1'b0;
                    zero_flag <= (mul_step[WIDTH-1:0] == '0);
                    done      <= 1'b1;
                    cnt       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_nb_seq.sv
// Directed bench for alu_nb_seq at WIDTH=8; outputs are sampled on the falling edge.
// Observed word is {done, carry_out, zero_flag, overflow, result}.
module tb_alu_nb_seq;
    localparam int W = 8;
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_SLL = 3'b011,
                           OP_OR = 3'b100, OP_SRL = 3'b101, OP_XOR = 3'b110, OP_MUL = 3'b111;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b;
    logic [2:0]   select;
    logic         busy, done, carry_out, zero_flag, overflow, state_dbg;
    logic [W-1:0] result;
    int           checks = 0;
    int           failures = 0;

    alu_nb_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .select(select),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .zero_flag(zero_flag), .overflow(overflow), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {done, carry_out, zero_flag, overflow, result};
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        select = op; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; select = OP_ADD; a = 8'h12; b = 8'h34;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 12'h200 || busy !== 1'b0 || state_dbg !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%h busy=%b st=%b exp=200 busy=0 st=0", obs(), busy, state_dbg);
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        issue(OP_ADD, 8'hFF, 8'h01);
        checks++;
        if (obs() !== 12'hE00) begin failures++; $display("FAIL add_ff_01 got=%h exp=e00", obs()); end
        issue(OP_ADD, 8'h7F, 8'h01);
        checks++;
        if (obs() !== 12'h980) begin failures++; $display("FAIL add_7f_01 got=%h exp=980", obs()); end
        @(negedge clk);
        checks++;
        if (obs() !== 12'h180) begin failures++; $display("FAIL add_hold got=%h exp=180", obs()); end
    endtask

    task automatic test_sub();
        issue(OP_SUB, 8'h80, 8'h01);
        checks++;
        if (obs() !== 12'hD7F) begin failures++; $display("FAIL sub_80_01 got=%h exp=d7f", obs()); end
        issue(OP_SUB, 8'h00, 8'h01);
        checks++;
        if (obs() !== 12'h8FF) begin failures++; $display("FAIL sub_00_01 got=%h exp=8ff", obs()); end
    endtask

    task automatic test_logic();
        issue(OP_AND, 8'hF0, 8'h3C);
        checks++;
        if (obs() !== 12'h830) begin failures++; $display("FAIL and got=%h exp=830", obs()); end
        issue(OP_OR, 8'hF0, 8'h0F);
        checks++;
        if (obs() !== 12'h8FF) begin failures++; $display("FAIL or got=%h exp=8ff", obs()); end
        issue(OP_XOR, 8'hAA, 8'hFF);
        checks++;
        if (obs() !== 12'h855) begin failures++; $display("FAIL xor got=%h exp=855", obs()); end
    endtask

    // Shift amount is b[2:0]: 09 -> 1, 0F -> 7.
    task automatic test_shift();
        issue(OP_SLL, 8'h81, 8'h09);
        checks++;
        if (obs() !== 12'h802) begin failures++; $display("FAIL sll_81_09 got=%h exp=802", obs()); end
        issue(OP_SRL, 8'h81, 8'h0F);
        checks++;
        if (obs() !== 12'h801) begin failures++; $display("FAIL srl_81_0f got=%h exp=801", obs()); end
        issue(OP_SRL, 8'h40, 8'h0F);
        checks++;
        if (obs() !== 12'hA00) begin failures++; $display("FAIL srl_40_0f got=%h exp=a00", obs()); end
    endtask

    task automatic test_mul();
        int n;
        issue(OP_MUL, 8'h0F, 8'h11);
        n = 0;
        while (busy && n < 20) begin n++; @(negedge clk); end
        checks++;
        if (n !== 8) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=8", n); end
        checks++;
        if (obs() !== 12'h8FF) begin failures++; $display("FAIL mul_0f_11 got=%h exp=8ff", obs()); end
        @(negedge clk);
        issue(OP_MUL, 8'h10, 8'h10);
        checks++;
        if (obs() !== 12'h0FF || busy !== 1'b1) begin
            failures++; $display("FAIL mul_hold got=%h busy=%b exp=0ff busy=1", obs(), busy);
        end
        n = 0;
        while (busy && n < 20) begin n++; @(negedge clk); end
        checks++;
        if (n !== 8 || obs() !== 12'hE00) begin
            failures++; $display("FAIL mul_10_10 got=%h cycles=%0d exp=e00 cycles=8", obs(), n);
        end
    endtask

    task automatic test_busy_ignore();
        int ndone;
        logic [11:0] at_done;
        ndone = 0; at_done = '0;
        issue(OP_MUL, 8'h03, 8'h05);
        select = OP_XOR; a = 8'hFF; b = 8'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin ndone++; at_done = obs(); end
            @(negedge clk);
        end
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL busy_ignore_dones got=%0d exp=1", ndone); end
        checks++;
        if (at_done !== 12'h80F) begin failures++; $display("FAIL busy_ignore_result got=%h exp=80f", at_done); end
    endtask

    task automatic test_back_to_back();
        select = OP_ADD; a = 8'h01; b = 8'h02; start = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== 12'h803) begin failures++; $display("FAIL b2b_first got=%h exp=803", obs()); end
        select = OP_SUB; a = 8'h05; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (obs() !== 12'hC04) begin failures++; $display("FAIL b2b_second got=%h exp=c04", obs()); end
        @(negedge clk);
        checks++;
        if (obs() !== 12'h404) begin failures++; $display("FAIL b2b_idle got=%h exp=404", obs()); end
    endtask

    task automatic test_reset_mid_mul();
        int ndone;
        issue(OP_MUL, 8'h0F, 8'h11);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== 12'h200 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_mul got=%h busy=%b exp=200 busy=0", obs(), busy);
        end
        reset = 1'b0;
        issue(OP_ADD, 8'h02, 8'h03);
        checks++;
        if (obs() !== 12'h805) begin failures++; $display("FAIL add_after_reset got=%h exp=805", obs()); end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0 || obs() !== 12'h005) begin
            failures++; $display("FAIL no_stray_done got=%h dones=%0d exp=005 dones=0", obs(), ndone);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; select = OP_ADD;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_mul();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
